// File: rtl/inv_add_round_key_stage_if.sv
// Bus bundle for the AES-128 decryption AddRoundKey stage: upstream beat,
// key-store lookup and downstream beat. The stage connects through the slave modport.
interface inv_add_round_key_stage_if;
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [15:0][7:0] in_state;
    logic [3:0]       key_round;
    logic [15:0][7:0] round_key;
    logic             out_valid;
    logic             out_ready;
    logic [15:0][7:0] out_state;
    logic [3:0]       out_round;
    logic             out_mix_en;
    logic             out_last;
    logic             seq_err;

    modport master (
        output in_valid, in_first, in_state, round_key, out_ready,
        input  in_ready, key_round, out_valid, out_state, out_round,
               out_mix_en, out_last, seq_err
    );

    modport slave (
        input  in_valid, in_first, in_state, round_key, out_ready,
        output in_ready, key_round, out_valid, out_state, out_round,
               out_mix_en, out_last, seq_err
    );
endinterface

// File: rtl/inv_add_round_key_stage.sv
// AES-128 decryption AddRoundKey stage: XORs each beat with the key of its round
// (NR down to 0), tags it for InvMixColumns routing and queues it in a 2-entry skid buffer.
module inv_add_round_key_stage #(
    parameter int NR = 10
) (
    input logic                      clk,
    input logic                      reset,
    inv_add_round_key_stage_if.slave bus
);
    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [15:0][7:0] state;
        logic [3:0]       round;
        logic             mix_en;
        logic             last;
    } entry_t;

    state_t     st, st_nxt;
    logic [3:0] r, r_nxt;
    logic       seq_err_q, seq_err_nxt;
    logic       in_ready_q;
    logic       accept, enq, deq;
    logic [3:0] r_used;
    entry_t     wr_entry;

    assign accept = bus.in_valid && in_ready_q;

    // Round FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            r         <= NR_L;
            seq_err_q <= 1'b0;
        end else begin
            st        <= st_nxt;
            r         <= r_nxt;
            seq_err_q <= seq_err_nxt;
        end
    end

    // Round FSM: next state. The counter only moves on accepted beats.
    always_comb begin
        // NOTE: every variable gets a hold-value default first so no latch is inferred.
        st_nxt      = st;
        r_nxt       = r;
        seq_err_nxt = seq_err_q;
        if (accept) begin
            unique case (st)
                IDLE: begin
                    if (bus.in_first) begin
                        st_nxt = RUN;
                        r_nxt  = NR_M1;
                    end else begin
                        seq_err_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.in_first) begin
                        r_nxt       = NR_M1;
                        seq_err_nxt = 1'b1;
                    end else if (r == 4'd0) begin
                        st_nxt = IDLE;
                    end else begin
                        r_nxt = r - 4'd1;
                    end
                end
            endcase
        end
    end

    // Round FSM: outputs. A non-first beat arriving in IDLE is dropped here.
    always_comb begin
        r_used   = (st == IDLE || bus.in_first) ? NR_L : r;
        enq      = accept && (st == RUN || bus.in_first);
        wr_entry = '{state:  bus.in_state ^ bus.round_key,
                     round:  r_used,
                     mix_en: (r_used != 4'd0) && (r_used != NR_L),
                     last:   (r_used == 4'd0)};
    end

    assign bus.key_round = r_used;
    assign bus.seq_err   = seq_err_q;

    entry_t     mem [2];
    entry_t     head;
    logic       rd_ptr, wr_ptr;
    logic [1:0] count, count_nxt;

    assign deq       = (count != 2'd0) && bus.out_ready;
    assign count_nxt = count + 2'(enq) - 2'(deq);

    // NOTE: storage is not reset; outputs are gated by occupancy, so stale data never shows.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            count      <= count_nxt;
            in_ready_q <= (count_nxt != 2'd2);
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (count != 2'd0);
    assign bus.out_state  = bus.out_valid ? head.state  : '0;
    assign bus.out_round  = bus.out_valid ? head.round  : 4'd0;
    assign bus.out_mix_en = bus.out_valid && head.mix_en;
    assign bus.out_last   = bus.out_valid && head.last;
endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Directed bench for inv_add_round_key_stage: FIPS-197 vectors, full-rate block,
// back-pressure, sequencing errors and mid-block reset.
module tb_inv_add_round_key_stage;
    localparam int NR = 10;

    typedef struct packed {
        logic         valid;
        logic [127:0] state;
        logic [3:0]   round;
        logic         mix;
        logic         last;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    inv_add_round_key_stage_if bus ();

    inv_add_round_key_stage #(.NR(NR)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Key store: rounds 10 and 0 are the FIPS-197 C.1 keys, the rest a byte pattern.
    function automatic logic [127:0] key_of(input logic [3:0] k);
        logic [7:0] b;
        case (k)
            4'd10:   return 128'h13111d7fe3944a17f307a78b4d2b30c5;
            4'd0:    return 128'h000102030405060708090a0b0c0d0e0f;
            default: begin
                b = 8'(k) * 8'h11;
                return {16{b}};
            end
        endcase
    endfunction

    always_comb bus.round_key = key_of(bus.key_round);

    function automatic obs_t observe();
        return {bus.out_valid, bus.out_state, bus.out_round, bus.out_mix_en, bus.out_last};
    endfunction

    function automatic obs_t expect_beat(input logic [127:0] s, input logic [3:0] rd);
        return '{valid: 1'b1, state: s ^ key_of(rd), round: rd,
                 mix: (rd != 4'd0) && (rd != 4'd10), last: (rd == 4'd0)};
    endfunction

    task automatic drive(input logic v, input logic f, input logic [127:0] s);
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_state = s;
    endtask

    task automatic test_reset();
        obs_t zero;
        zero = '0;
        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (observe() !== zero) begin
            n_bad++;
            $display("FAIL reset outputs: got %h want %h", observe(), zero);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.key_round !== 4'd10 || bus.seq_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset key_round/seq_err: got %0d/%b want 10/0", bus.key_round, bus.seq_err);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Tests 1-3: one FIPS block at full rate, one output per cycle, one cycle latency.
    task automatic test_fips_block();
        logic [127:0] st_k [11];
        obs_t         exp;
        for (int k = 0; k < 11; k++) st_k[k] = {16{8'(8'hc0 + k)}};
        st_k[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        st_k[10] = 128'h00102030405060708090a0b0c0d0e0f0;
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            if (c < 11) drive(1'b1, c == 0, st_k[c]);
            else        drive(1'b0, 1'b0, '0);
            #1;
            if (c < 11) begin
                n_cmp++;
                if (bus.key_round !== 4'(10 - c) || bus.in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL block key_round beat %0d: got %0d rdy %b want %0d rdy 1",
                             c, bus.key_round, bus.in_ready, 10 - c);
                end
            end
            if (c > 0) begin
                exp = expect_beat(st_k[c-1], 4'(11 - c));
                n_cmp++;
                if (observe() !== exp) begin
                    n_bad++;
                    $display("FAIL block out beat %0d: got %h want %h", c - 1, observe(), exp);
                end
            end
            if (c == 1) begin
                n_cmp++;
                if (bus.out_state !== 128'h7ad5fda789ef4e272bca100b3d9ff59f) begin
                    n_bad++;
                    $display("FAIL fips first state: got %h want 7ad5fda789ef4e272bca100b3d9ff59f",
                             bus.out_state);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if (bus.out_state !== 128'h00112233445566778899aabbccddeeff || bus.out_last !== 1'b1) begin
                    n_bad++;
                    $display("FAIL fips final state: got %h last %b want 00112233445566778899aabbccddeeff last 1",
                             bus.out_state, bus.out_last);
                end
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.key_round !== 4'd10) begin
            n_bad++;
            $display("FAIL block end: got valid %b key_round %0d want 0 10", bus.out_valid, bus.key_round);
        end
        @(negedge clk);
    endtask

    // Test 4: five stalled cycles while streaming a block, then drain in order.
    task automatic test_stall();
        obs_t q [$];
        obs_t exp;
        int   idx = 0;
        int   popped = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 60 && popped < 11; c++) begin
            if (idx < 11) drive(1'b1, idx == 0, {16{8'(8'h30 + idx)}});
            else          drive(1'b0, 1'b0, '0);
            #1;
            if (c < 5) begin
                n_cmp++;
                if (bus.in_ready !== (c < 2)) begin
                    n_bad++;
                    $display("FAIL stall in_ready cycle %0d: got %b want %b", c, bus.in_ready, c < 2);
                end
            end
            if (c >= 1 && c < 5) begin
                n_cmp++;
                if (q.size() == 0 || observe() !== q[0]) begin
                    n_bad++;
                    $display("FAIL stall hold cycle %0d: got %h", c, observe());
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall extra beat: got %h want none", observe());
                end else begin
                    exp = q.pop_front();
                    if (observe() !== exp) begin
                        n_bad++;
                        $display("FAIL stall order: got %h want %h", observe(), exp);
                    end
                end
                popped++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(expect_beat({16{8'(8'h30 + idx)}}, 4'(10 - idx)));
                idx++;
            end
            @(negedge clk);
            bus.out_ready = (c + 1 >= 5);
        end
        #1;
        n_cmp++;
        if (popped !== 11 || q.size() !== 0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall totals: got popped %0d left %0d valid %b want 11 0 0",
                     popped, q.size(), bus.out_valid);
        end
        @(negedge clk);
    endtask

    // Test 5: stray beat in IDLE is dropped; in_first mid-block restarts at round 10.
    task automatic test_seq_err();
        logic [3:0] rounds [7] = '{4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd10};
        obs_t       exp;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 128'hdeadbeef);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.seq_err !== 1'b0) begin
            n_bad++;
            $display("FAIL seq idle pre: got rdy %b err %b want 1 0", bus.in_ready, bus.seq_err);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.seq_err !== 1'b1) begin
            n_bad++;
            $display("FAIL seq idle drop: got valid %b err %b want 0 1", bus.out_valid, bus.seq_err);
        end
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        for (int c = 0; c <= 7; c++) begin
            if (c < 7) drive(1'b1, c == 0 || c == 6, {16{8'(8'h50 + c)}});
            else       drive(1'b0, 1'b0, '0);
            #1;
            if (c < 7) begin
                n_cmp++;
                if (bus.key_round !== rounds[c]) begin
                    n_bad++;
                    $display("FAIL seq key_round beat %0d: got %0d want %0d", c, bus.key_round, rounds[c]);
                end
            end
            if (c == 0 || c == 6) begin
                n_cmp++;
                if (bus.seq_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL seq err early cycle %0d: got %b want 0", c, bus.seq_err);
                end
            end
            if (c > 0) begin
                exp = expect_beat({16{8'(8'h50 + c - 1)}}, rounds[c-1]);
                n_cmp++;
                if (observe() !== exp) begin
                    n_bad++;
                    $display("FAIL seq out beat %0d: got %h want %h", c - 1, observe(), exp);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (bus.seq_err !== 1'b1) begin
                    n_bad++;
                    $display("FAIL seq restart err: got %b want 1", bus.seq_err);
                end
            end
            @(negedge clk);
        end
    endtask

    // Test 6: reset with two beats buffered at r=6, then a clean restart.
    task automatic test_reset_mid();
        obs_t exp;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            bus.out_ready = (c < 3);
            drive(1'b1, c == 0, {16{8'(8'h70 + c)}});
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1 || bus.key_round !== 4'(10 - c)) begin
                n_bad++;
                $display("FAIL mid fill beat %0d: got rdy %b key %0d want 1 %0d",
                         c, bus.in_ready, bus.key_round, 10 - c);
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, '0);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.key_round !== 4'd6) begin
            n_bad++;
            $display("FAIL mid full: got valid %b rdy %b key %0d want 1 0 6",
                     bus.out_valid, bus.in_ready, bus.key_round);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.key_round !== 4'd10
            || bus.out_state !== 128'h0) begin
            n_bad++;
            $display("FAIL mid async reset: got valid %b rdy %b key %0d want 0 1 10",
                     bus.out_valid, bus.in_ready, bus.key_round);
        end
        #1;
        reset = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100);
        #1;
        n_cmp++;
        if (bus.key_round !== 4'd10) begin
            n_bad++;
            $display("FAIL mid restart key: got %0d want 10", bus.key_round);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        #1;
        exp = expect_beat(128'h0f0e0d0c0b0a09080706050403020100, 4'd10);
        n_cmp++;
        if (observe() !== exp) begin
            n_bad++;
            $display("FAIL mid restart out: got %h want %h", observe(), exp);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid stale beat: got valid %b want 0", bus.out_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fips_block();
        test_stall();
        test_seq_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
